// File: rtl/usb_router_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : usb_router_pkg                                         |
// | Description : Shared types and constants for the USB packet router.  |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package usb_router_pkg;

  // Arbiter state: waiting for a committed packet, or owning one channel
  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // Arbitration policies selectable through ARB_MODE
  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

endpackage
`default_nettype wire

// File: rtl/usb_chan_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : usb_chan_fifo                                          |
// | Description : One router channel. Byte FIFO with a commit pointer so |
// |               that only whole packets become readable, rollback on   |
// |               abort/overflow, and a DROP mode that swallows the rest |
// |               of a packet which overflowed.                          |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module usb_chan_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  input  logic              abort,
  input  logic              pop,
  input  logic              ovf_clr,
  output logic [DATA_W-1:0] head_data,
  output logic              head_last,
  output logic [DATA_W-1:0] next_data,
  output logic              next_last,
  output logic              empty,
  output logic              full,
  output logic              ovf
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] cmt_ptr_q, cmt_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             drop_q, drop_d;
  logic             ovf_q, ovf_d;
  logic [DATA_W:0]  mem_q [DEPTH];

  logic [PTR_W-1:0] w_occ;
  logic [PTR_W-1:0] w_rd_nxt;
  logic             w_store;

  // Occupancy counts uncommitted bytes too; readability counts committed only
  assign w_occ    = wr_ptr_q - rd_ptr_q;
  assign full     = (w_occ == PTR_W'(DEPTH));
  assign empty    = (cmt_ptr_q == rd_ptr_q);
  assign ovf      = ovf_q;
  assign w_rd_nxt = rd_ptr_q + 1'b1;

  // Two read ports: the head, plus the following byte so the output stage
  // can refill on the same cycle it pops (that byte is inside the same
  // committed packet whenever the head is not a last byte)
  assign {head_last, head_data} = mem_q[rd_ptr_q[AW-1:0]];
  assign {next_last, next_data} = mem_q[w_rd_nxt[AW-1:0]];

  // Write/commit/rollback decisions; abort outranks any same-cycle write
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    cmt_ptr_d = cmt_ptr_q;
    rd_ptr_d  = pop ? w_rd_nxt : rd_ptr_q;
    drop_d    = drop_q;
    ovf_d     = ovf_q & ~ovf_clr;
    w_store   = 1'b0;
    if (abort) begin
      wr_ptr_d = cmt_ptr_q;
      drop_d   = 1'b0;
    end else if (wr_en) begin
      if (drop_q) begin
        if (wr_last) drop_d = 1'b0;
      end else if (full) begin
        // Full is judged before any same-cycle pop frees a slot
        ovf_d    = 1'b1;
        wr_ptr_d = cmt_ptr_q;
        drop_d   = ~wr_last;
      end else begin
        w_store  = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (wr_last) cmt_ptr_d = wr_ptr_q + 1'b1;
      end
    end
  end

  // Pointer and flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      cmt_ptr_q <= '0;
      rd_ptr_q  <= '0;
      drop_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      cmt_ptr_q <= cmt_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      drop_q    <= drop_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage array, entry = {last, data}; contents need no reset
  always_ff @(posedge clk) begin
    if (w_store) mem_q[wr_ptr_q[AW-1:0]] <= {wr_last, wr_data};
  end

endmodule
`default_nettype wire

// File: rtl/usb_pkt_router.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : usb_pkt_router                                         |
// | Description : Steers received bytes into N_CH packet FIFOs and drains|
// |               whole packets through one registered valid/ready port, |
// |               tagged with source channel and last.                   |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module usb_pkt_router
  import usb_router_pkg::*;
#(
  parameter  int N_CH     = 4,
  parameter  int DATA_W   = 8,
  parameter  int DEPTH    = 16,
  parameter  int ARB_MODE = 0,
  localparam int CH_W     = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_last,
  output logic [N_CH-1:0]   ch_empty,
  output logic [N_CH-1:0]   ch_full,
  output logic [N_CH-1:0]   ovf,
  input  logic [N_CH-1:0]   ovf_clr
);

  arb_state_e        state_q, state_d;
  logic [CH_W-1:0]   gnt_q, gnt_d;
  logic [CH_W-1:0]   rr_q, rr_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic              out_last_q, out_last_d;

  logic [N_CH-1:0]             w_empty;
  logic [N_CH-1:0]             w_pop;
  logic [N_CH-1:0][DATA_W-1:0] w_head_data;
  logic [N_CH-1:0][DATA_W-1:0] w_next_data;
  logic [N_CH-1:0]             w_head_last;
  logic [N_CH-1:0]             w_next_last;
  logic [CH_W-1:0]             w_base;
  logic [CH_W-1:0]             w_pick;
  logic                        w_any;
  logic [CH_W-1:0]             w_rr_next;

  // Channel reached k steps after base, wrapping at N_CH
  function automatic logic [CH_W-1:0] scan_idx(input logic [CH_W-1:0] base, input int k);
    int s;
    s = (int'(base) + k) % N_CH;
    return CH_W'(s);
  endfunction

  // One FIFO per channel; the write demux is the channel-match enable
  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    assign w_pop[i] = out_valid_q && out_ready && (gnt_q == CH_W'(i));

    usb_chan_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (in_valid && (in_ch == CH_W'(i))),
      .wr_data   (in_data),
      .wr_last   (in_last),
      .abort     (in_abort),
      .pop       (w_pop[i]),
      .ovf_clr   (ovf_clr[i]),
      .head_data (w_head_data[i]),
      .head_last (w_head_last[i]),
      .next_data (w_next_data[i]),
      .next_last (w_next_last[i]),
      .empty     (w_empty[i]),
      .full      (ch_full[i]),
      .ovf       (ovf[i])
    );
  end

  assign ch_empty  = w_empty;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_last  = out_last_q;

  assign w_base    = (ARB_MODE == ARB_FIXED) ? '0 : rr_q;
  assign w_rr_next = (gnt_q == CH_W'(N_CH - 1)) ? '0 : gnt_q + 1'b1;

  // Pick the first channel holding a committed packet, scanning from w_base
  always_comb begin
    w_pick = '0;
    w_any  = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (!w_any && !w_empty[scan_idx(w_base, k)]) begin
        w_any  = 1'b1;
        w_pick = scan_idx(w_base, k);
      end
    end
  end

  // Arbiter next state and output register loading
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rr_d        = rr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_last_d  = out_last_q;
    case (state_q)
      ARB_IDLE: begin
        if (w_any) begin
          state_d = ARB_GRANT;
          gnt_d   = w_pick;
        end
      end
      ARB_GRANT: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = w_head_data[gnt_q];
          out_last_d  = w_head_last[gnt_q];
          out_ch_d    = gnt_q;
        end else if (out_ready) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            state_d     = ARB_IDLE;
            rr_d        = w_rr_next;
          end else begin
            out_data_d  = w_next_data[gnt_q];
            out_last_d  = w_next_last[gnt_q];
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Arbiter and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      gnt_q       <= '0;
      rr_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rr_q        <= rr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule
`default_nettype wire
